// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cic_pkg
// Purpose : Shared types and helpers for the CIC decimator.
//           - cic_reg_w      : internal register width for a configuration
//           - rate_idx_t     : rate-index type used for rate_log2 handling
//           - cic_clamp_rate : limits a requested rate_log2 to the build max
// Rev     : 1.0  initial release
// ============================================================================
package cic_pkg;

  // Wide enough for log2 of any practical MAX_RATE.
  typedef logic [7:0] rate_idx_t;

  // Bit growth of a CIC is STAGES*log2(R*M); adding it to the input width
  // guarantees the final comb output is exact despite integrator wrap.
  function automatic int cic_reg_w(input int width, input int stages,
                                   input int max_rate, input int diff_delay);
    return width + stages * $clog2(max_rate * diff_delay);
  endfunction

  function automatic rate_idx_t cic_clamp_rate(input rate_idx_t req,
                                               input rate_idx_t max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cic_comb_stage.sv
`default_nettype none
// ============================================================================
// Module  : cic_comb_stage
// Purpose : One comb section y = x - x[n-DELAY], advanced only by a strobe.
// Ports   : clk, rst      clock and synchronous active-high reset
//           clr           synchronous flush of all section state
//           stb_in, x     strobe and data from the previous section
//           stb_out, y    registered strobe and difference to the next one
// Rev     : 1.0  initial release
// ============================================================================
module cic_comb_stage #(
  parameter int DATA_W = 34,
  parameter int DELAY  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     stb_in,
  input  logic signed [DATA_W-1:0] x,
  output logic                     stb_out,
  output logic signed [DATA_W-1:0] y
);

  logic signed [DATA_W-1:0] dly [DELAY];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      stb_out <= 1'b0;
      y       <= '0;
      for (int i = 0; i < DELAY; i++) dly[i] <= '0;
    end else begin
      // The strobe always moves one section per cycle; data only on strobes.
      stb_out <= stb_in;
      if (stb_in) begin
        y      <= x - dly[DELAY-1];
        dly[0] <= x;
        for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
// Module  : cic_decimator
// Purpose : Single-clock CIC decimator with run-time power-of-two rate and
//           exact gain normalisation.
// Ports   : clk, rst            clock, synchronous active-high reset
//           cfg_load, rate_log2 latch new rate and flush all filter state
//           in_valid, in_data   input sample stream (signed)
//           out_valid, out_data decimated, normalised output stream
//           rate_cur            active rate_log2
// Rev     : 1.0  initial release
// ============================================================================
module cic_decimator
  import cic_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int STAGES     = 3,
  parameter int MAX_RATE   = 64,
  parameter int DIFF_DELAY = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_load,
  input  logic [$clog2(MAX_RATE):0]    rate_log2,
  input  logic                         in_valid,
  input  logic signed [WIDTH-1:0]      in_data,
  output logic                         out_valid,
  output logic signed [WIDTH-1:0]      out_data,
  output logic [$clog2(MAX_RATE):0]    rate_cur
);

  localparam int REG_W    = cic_reg_w(WIDTH, STAGES, MAX_RATE, DIFF_DELAY);
  localparam int MAX_LOG2 = $clog2(MAX_RATE);
  localparam int RATE_W   = MAX_LOG2 + 1;
  localparam int CNT_W    = MAX_LOG2;
  localparam int LOG2M    = $clog2(DIFF_DELAY);

  // --------------------------------------------------------------------------
  // Integrators (input rate)
  // --------------------------------------------------------------------------
  logic signed [REG_W-1:0] in_ext;
  logic signed [REG_W-1:0] integ [STAGES];

  assign in_ext = {{(REG_W-WIDTH){in_data[WIDTH-1]}}, in_data};

  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (in_valid) begin
      integ[0] <= integ[0] + in_ext;
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // --------------------------------------------------------------------------
  // Rate register, decimation counter and decimation register
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W:0]          rate_len;
  logic                    block_end;
  logic signed [REG_W-1:0] dec_data;
  logic                    dec_stb;

  assign rate_len  = (CNT_W+1)'(1) << rate_cur;
  assign block_end = (cnt == CNT_W'(rate_len - (CNT_W+1)'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_cur <= RATE_W'(MAX_LOG2);
    end else if (cfg_load) begin
      rate_cur <= RATE_W'(cic_clamp_rate(rate_idx_t'(rate_log2),
                                         rate_idx_t'(MAX_LOG2)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      cnt      <= '0;
      dec_data <= '0;
      dec_stb  <= 1'b0;
    end else begin
      dec_stb <= 1'b0;
      if (in_valid) begin
        if (block_end) begin
          cnt      <= '0;
          dec_data <= integ[STAGES-1];  // pre-update value by design
          dec_stb  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Comb pipeline (decimated rate, strobe-enabled)
  // --------------------------------------------------------------------------
  logic signed [REG_W-1:0] comb_data [STAGES+1];
  logic                    comb_stb  [STAGES+1];

  assign comb_data[0] = dec_data;
  assign comb_stb[0]  = dec_stb;

  for (genvar s = 0; s < STAGES; s++) begin : g_comb
    cic_comb_stage #(
      .DATA_W (REG_W),
      .DELAY  (DIFF_DELAY)
    ) u_comb (
      .clk     (clk),
      .rst     (rst),
      .clr     (cfg_load),
      .stb_in  (comb_stb[s]),
      .x       (comb_data[s]),
      .stb_out (comb_stb[s+1]),
      .y       (comb_data[s+1])
    );
  end

  // --------------------------------------------------------------------------
  // Normalisation: DC gain is (R*M)^STAGES, a power of two, so an arithmetic
  // shift divides it out exactly.
  // --------------------------------------------------------------------------
  int                      shift_amt;
  logic signed [WIDTH-1:0] out_next;

  always_comb begin
    shift_amt = STAGES * (int'(rate_cur) + LOG2M);
    out_next  = WIDTH'(comb_data[STAGES] >>> shift_amt);
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_load) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= comb_stb[STAGES];
      if (comb_stb[STAGES]) out_data <= out_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module  : tb_cic_decimator
// Purpose : Self-checking bench for cic_decimator. Three builds share one
//           input stream: (S=3,M=1), (S=1,M=1), (S=3,M=2), all MAX_RATE=64.
//           The reference forms the equivalent high-rate FIR (boxcar of
//           length R*M convolved STAGES times) over the accepted samples.
// Rev     : 1.0  initial release
// ============================================================================
module tb_cic_decimator;

  localparam int ND = 3;
  localparam int RW = 7;

  function automatic int st(input int d); return (d == 1) ? 1 : 3; endfunction
  function automatic int mm(input int d); return (d == 2) ? 2 : 1; endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_load = 1'b0;
  logic [RW-1:0] rate_log2 = '0;
  logic in_valid = 1'b0;
  logic signed [15:0] in_data = '0;

  logic [ND-1:0]         ov;
  logic [ND-1:0][15:0]   od;
  logic [ND-1:0][RW-1:0] rc;

  always #5 clk = ~clk;

  cic_decimator #(.WIDTH(16), .STAGES(3), .MAX_RATE(64), .DIFF_DELAY(1)) dut0 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .rate_log2(rate_log2),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[0]), .out_data(od[0]), .rate_cur(rc[0]));
  cic_decimator #(.WIDTH(16), .STAGES(1), .MAX_RATE(64), .DIFF_DELAY(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .rate_log2(rate_log2),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[1]), .out_data(od[1]), .rate_cur(rc[1]));
  cic_decimator #(.WIDTH(16), .STAGES(3), .MAX_RATE(64), .DIFF_DELAY(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .rate_log2(rate_log2),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(ov[2]), .out_data(od[2]), .rate_cur(rc[2]));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int     cyc = 0;
  int     model_rate = 6;
  int     acc = 0;
  int     hist[$];
  longint h[ND][512];
  int     hlen[ND];
  logic   expv[ND][16];
  int     expd[ND][16];

  task automatic build_h();
    longint a[512];
    longint b[512];
    int blen;
    int len;
    for (int d = 0; d < ND; d++) begin
      blen = (1 << model_rate) * mm(d);
      len  = 1;
      for (int i = 0; i < 512; i++) a[i] = 0;
      a[0] = 1;
      for (int s = 0; s < st(d); s++) begin
        for (int i = 0; i < 512; i++) b[i] = 0;
        for (int i = 0; i < len; i++)
          for (int j = 0; j < blen; j++) b[i+j] += a[i];
        len = len + blen - 1;
        a = b;
      end
      for (int i = 0; i < 512; i++) h[d][i] = a[i];
      hlen[d] = len;
    end
  endtask

  // n-th output (1-based) of build d: filter evaluated at accepted-sample
  // index n*R-1-S, then divided by (R*M)^S with floor rounding.
  function automatic longint model_out(input int d, input int n);
    longint sum;
    int base;
    int k;
    sum  = 0;
    base = n * (1 << model_rate) - 1 - st(d);
    for (int i = 0; i < hist.size(); i++) begin
      k = base - i;
      if (k >= 0 && k < hlen[d]) sum += longint'(hist[i]) * h[d][k];
    end
    return sum >>> (st(d) * (model_rate + $clog2(mm(d))));
  endfunction

  task automatic flush();
    hist.delete();
    acc = 0;
    for (int d = 0; d < ND; d++)
      for (int i = 0; i < 16; i++) begin expv[d][i] = 1'b0; expd[d][i] = 0; end
    build_h();
  endtask

  initial forever begin
    logic signed [15:0] t;
    int slot;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_rate = 6;
      flush();
    end else if (cfg_load) begin
      model_rate = (int'(rate_log2) > 6) ? 6 : int'(rate_log2);
      flush();
    end else if (in_valid) begin
      hist.push_back(int'(in_data));
      acc++;
      if (acc % (1 << model_rate) == 0) begin
        for (int d = 0; d < ND; d++) begin
          slot = (cyc + st(d) + 1) % 16;
          t = 16'(model_out(d, acc / (1 << model_rate)));
          expv[d][slot] = 1'b1;
          expd[d][slot] = int'(t);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard and per-phase statistics (sampled mid-cycle)
  // --------------------------------------------------------------------------
  int cnt_out[ND];
  int nz_cnt[ND];
  int nz_val[ND];
  int last_out[ND];

  task automatic clear_stats();
    for (int d = 0; d < ND; d++) begin
      cnt_out[d] = 0; nz_cnt[d] = 0; nz_val[d] = 0; last_out[d] = 0;
    end
  endtask

  initial forever begin
    int s;
    @(negedge clk);
    s = cyc % 16;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("sb_valid_d%0d", d), longint'(ov[d]), longint'(expv[d][s]));
      if (expv[d][s])
        check($sformatf("sb_data_d%0d", d), $signed(od[d]), expd[d][s]);
      expv[d][s] = 1'b0;
      if (ov[d]) begin
        cnt_out[d]++;
        last_out[d] = int'($signed(od[d]));
        if (od[d] != 16'd0) begin nz_cnt[d]++; nz_val[d] = int'($signed(od[d])); end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_cfg(input int r);
    cfg_load = 1'b1; rate_log2 = RW'(r); in_valid = 1'b0;
    tick();
    cfg_load = 1'b0;
  endtask

  typedef struct {
    int rate; int value; int period; int ncyc; int exp_out; int exp_rate;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k;
    int na;
    int r;

    vecs[0] = '{3,    100, 1, 200,    100, 3};
    vecs[1] = '{3,    -64, 2, 400,    -64, 3};
    vecs[2] = '{6,  32767, 1, 800,  32767, 6};
    vecs[3] = '{0,     -5, 1,  40,     -5, 0};
    vecs[4] = '{9, -32768, 1, 800, -32768, 6};
    vecs[5] = '{2,      7, 3, 120,      7, 2};

    repeat (3) tick();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_rate_d%0d", d), rc[d], 6);
      check($sformatf("rst_valid_d%0d", d), ov[d], 0);
      check($sformatf("rst_data_d%0d", d), $signed(od[d]), 0);
    end
    rst = 1'b0;
    tick();

    // Table-driven DC phases
    for (int v = 0; v < 6; v++) begin
      do_cfg(vecs[v].rate);
      clear_stats();
      na = 0;
      for (int i = 0; i < vecs[v].ncyc; i++) begin
        in_valid = (i % vecs[v].period) == 0;
        in_data  = 16'(vecs[v].value);
        if (in_valid) na++;
        tick();
      end
      in_valid = 1'b0;
      repeat (10) tick();
      for (int d = 0; d < ND; d++) begin
        check($sformatf("vec%0d_rate_d%0d", v, d), rc[d], vecs[v].exp_rate);
        check($sformatf("vec%0d_dc_d%0d", v, d), last_out[d], vecs[v].exp_out);
      end
      check($sformatf("vec%0d_count", v), cnt_out[0], na >> vecs[v].exp_rate);
    end

    // Single impulse, STAGES=1 build yields exactly one 512/8 output
    do_cfg(3);
    clear_stats();
    in_valid = 1'b1; in_data = 16'sd512;
    tick();
    in_data = '0;
    repeat (79) tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("impulse_nz_count", nz_cnt[1], 1);
    check("impulse_value", nz_val[1], 64);
    check("impulse_out_count", cnt_out[1], 10);

    // Mid-stream cfg_load: sample with the load is dropped
    do_cfg(3);
    in_valid = 1'b1; in_data = 16'sd1000;
    repeat (5) tick();
    cfg_load = 1'b1; rate_log2 = 7'd2; in_data = 16'sd9999;
    tick();
    cfg_load = 1'b0; in_valid = 1'b0;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("load_valid_d%0d", d), ov[d], 0);
      check($sformatf("load_rate_d%0d", d), rc[d], 2);
    end
    in_valid = 1'b1; in_data = 16'sd50;
    repeat (4) tick();
    in_valid = 1'b0;
    k = 0;
    while (!ov[0] && k < 20) begin tick(); k++; end
    check("load_latency", k, 4);
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();

    // Reset mid-block, together with cfg_load requesting an over-range rate
    do_cfg(3);
    in_valid = 1'b1; in_data = 16'sd300;
    repeat (5) tick();
    rst = 1'b1; cfg_load = 1'b1; rate_log2 = 7'd9;
    tick();
    rst = 1'b0; cfg_load = 1'b0; in_valid = 1'b0;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("midrst_rate_d%0d", d), rc[d], 6);
      check($sformatf("midrst_valid_d%0d", d), ov[d], 0);
      check($sformatf("midrst_data_d%0d", d), $signed(od[d]), 0);
    end
    clear_stats();
    in_valid = 1'b1; in_data = 16'sd10;
    repeat (63) tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("midrst_no_early_out", cnt_out[0], 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    check("midrst_first_out", cnt_out[0], 1);
    do_cfg(9);
    check("clamp_rate", rc[0], 6);

    // Randomised phases against the reference model
    for (int p = 0; p < 5; p++) begin
      r = $urandom_range(0, 6);
      do_cfg(r);
      clear_stats();
      na = 0;
      for (int i = 0; i < 300; i++) begin
        in_valid = $urandom_range(0, 9) < 7;
        in_data  = 16'($urandom);
        if (in_valid) na++;
        tick();
      end
      in_valid = 1'b0;
      repeat (10) tick();
      check($sformatf("rand%0d_count", p), cnt_out[0], na >> r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cic_decimator.md
# cic_decimator

Parametrised, single-clock CIC decimator: signed two's-complement input stream, STAGES integrators at the input rate, run-time selectable power-of-two decimation, STAGES comb sections gated by a decimation strobe instead of a derived clock, and exact gain normalisation. It sits between a sample source (ADC or modulator front end) and downstream low-rate processing. Input and output use valid-qualified streams.

## Interface
- WIDTH, 16: input/output sample width, signed.
- STAGES, 3: number of integrator/comb pairs, 1..6.
- MAX_RATE, 64: largest decimation factor, power of 2, ≥2.
- DIFF_DELAY, 1: comb differential delay M, 1 or 2.
- clk  in  1  sole clock; one clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- cfg_load  in  1  pulse: latch rate_log2 and flush all filter state.
- rate_log2  in  $clog2(MAX_RATE)+1  log2 of decimation factor R.
- in_valid  in  1  in_data is a new sample this cycle.
- in_data  in  WIDTH  signed input sample.
- out_valid  out  1  one-cycle pulse per decimated sample.
- out_data  out  WIDTH  signed normalised output.
- rate_cur  out  $clog2(MAX_RATE)+1  currently active rate_log2.

## Operation
- REG_W = WIDTH + STAGES*$clog2(MAX_RATE*DIFF_DELAY). All internal arithmetic is signed REG_W and wraps modulo 2^REG_W (overflow is intentional).
- Input is sign-extended to REG_W.
- Integrators: registered chain, updated only on cycles with in_valid=1; stage k adds the registered value of stage k-1 (stage 0 adds the input).
- Decimation counter counts accepted samples 0..R-1. On the accept where count=R-1: counter returns to 0 and the last integrator's pre-update register value is captured into the decimation register with a strobe.
- Combs: STAGES registered sections, each with a DIFF_DELAY-deep delay line, advanced only by the strobe travelling down the pipe. y = x − x delayed by M strobes.
- Output: arithmetic right shift of the last comb by STAGES*(rate_log2 + log2 M), truncated to WIDTH LSBs, registered, with out_valid.
- DC gain after normalisation is exactly 1.
- rate_log2 > $clog2(MAX_RATE) is clamped to $clog2(MAX_RATE).
- rate_log2=0 means R=1: every accepted sample produces a strobe.
- cfg_load: the next edge clears all integrators, combs, delay lines, counter and in-flight strobes, and latches rate_cur. in_valid in the same cycle is dropped. out_valid is 0 the following cycle.
- cfg_load and rst asserted together: rst wins and rate_cur becomes $clog2(MAX_RATE).
- No backpressure: the consumer must accept every out_valid pulse.

## Timing
- Reset values: out_valid=0, out_data=0, rate_cur=$clog2(MAX_RATE), all internal state 0.
- Reset mid-stream aborts in-flight outputs; no out_valid appears until R further accepts after release.
- Latency: out_valid rises STAGES+1 cycles after the edge that accepts the R-th sample of a block, independent of in_valid gaps after that edge.
- Max throughput: in_valid may be 1 every cycle. Output rate is accepted-sample rate / R.
- Strobes never overlap in the comb pipe: R≥1 and pipe depth STAGES+1.
- For R=1 with continuous input, out_valid may stay high continuously.
- First STAGES*DIFF_DELAY+1 outputs after reset/cfg_load are the filter transient.

## Structure
- Package cic_pkg holds:
  - function cic_reg_w(WIDTH, STAGES, MAX_RATE, DIFF_DELAY)
  - the rate-index type for rate_log2
  - the clamp function
- Sub-module cic_comb_stage: one comb section with strobe enable, M-deep delay line, synchronous clear, strobe out. Instantiated STAGES times by generate.
- Integrator chain, counter, shifter and control stay in the top.

## Test plan
- WIDTH=16, STAGES=3, M=1, rate_log2=3, in_data=100 continuous -> after the transient, every out_valid carries 100; one out_valid per 8 accepts.
- Same configuration, in_data=−64 with in_valid toggling every other cycle -> steady outputs −64; out_valid spacing 16 cycles; latency STAGES+1 from the 8th accept.
- STAGES=1, rate_log2=3, single sample 512 then zeros -> exactly one output 64, all others 0.
- Full-scale 32767 continuous at R=MAX_RATE, STAGES=3, M=2 -> outputs 32767 in steady state, despite internal wrap.
- Mid-stream cfg_load with rate_log2=2 -> no out_valid the next cycle; rate_cur=2; the next out_valid comes STAGES+1 cycles after the 4th post-load accept; sample with cfg_load is dropped.
- rst asserted mid-block with rate_log2=9 requested on a MAX_RATE=64 build -> all outputs 0 and rate_cur=6 after reset; a subsequent cfg_load with rate_log2=9 clamps to 6.
